// File: rtl/barrett_reduce_pkg.sv
// Shared constants for the NTT reduction path: data width, modulus,
// modulus bit count, reducer latency and the Barrett constant derivation.
package barrett_reduce_pkg;

   localparam int unsigned     DATAWIDTH      = 32;
   localparam longint unsigned MODULUS        = 64'd343576577;
   localparam int unsigned     MOD_BITS       = 29;
   // Butterfly schedulers delay twiddle paths by this many cycles.
   localparam int unsigned     REDUCE_LATENCY = 4;

   // floor(2^(2m) / p); valid for m up to 31 with 64-bit arithmetic.
   function automatic longint unsigned barrett_mu(input longint unsigned p,
                                                  input int unsigned m);
      return (64'd1 << (2 * m)) / p;
   endfunction

   localparam longint unsigned MU_DEFAULT = barrett_mu(MODULUS, MOD_BITS);

endpackage

// File: rtl/barrett_reduce_if.sv
// Valid/ready product-in, residue-out bus between the Karatsuba multiplier,
// the Barrett reducer and the butterfly adder.
interface barrett_reduce_if #(
   parameter int unsigned DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_L;
   logic [DW-1:0] in_H;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_r;

   // Reducer side.
   modport slave (
      input  in_valid, in_L, in_H, out_ready,
      output in_ready, out_valid, out_r
   );

   // Producer/consumer side.
   modport master (
      output in_valid, in_L, in_H, out_ready,
      input  in_ready, out_valid, out_r
   );
endinterface

// File: rtl/barrett_reduce_mod_csub.sv
// Single conditional subtraction: y = (a >= P) ? a - P : a.
// Also used by the butterfly add/sub units for their final correction.
module mod_csub
   import barrett_reduce_pkg::*;
#(
   parameter int unsigned     DW = DATAWIDTH,
   parameter longint unsigned P  = MODULUS
) (
   input  logic [DW-1:0] a_i,
   output logic [DW-1:0] y_o
);

   localparam logic [DW-1:0] P_V = DW'(P);

   assign y_o = (a_i >= P_V) ? (a_i - P_V) : a_i;

endmodule

// File: rtl/barrett_reduce.sv
// Four-stage Barrett reducer: {in_H, in_L} mod P with valid/ready stalling.
// All stages advance together when the output register is free or being
// drained; bubbles travel through the pipe unchanged.
module barrett_reduce
   import barrett_reduce_pkg::*;
#(
   parameter int unsigned     DW = DATAWIDTH,
   parameter longint unsigned P  = MODULUS,
   parameter int unsigned     M  = MOD_BITS
) (
   input logic             clk,
   input logic             rst,
   barrett_reduce_if.slave bus
);

   localparam longint unsigned MU  = barrett_mu(P, M);
   localparam int unsigned     XW  = 2 * DW;
   localparam int unsigned     RW  = M + 2;
   localparam int unsigned     XSW = XW - (M - 1);
   localparam int unsigned     MUW = M + 1;
   localparam int unsigned     Q2W = XSW + MUW;

   localparam logic [Q2W-1:0] MU_Q = Q2W'(MU);
   localparam logic [RW-1:0]  P_R  = RW'(P);

   logic           adv;

   logic           v1_q, v1_d;
   logic [XW-1:0]  x1_q, x1_d;

   logic           v2_q, v2_d;
   logic [Q2W-1:0] q2_q, q2_d;
   logic [RW-1:0]  xl2_q, xl2_d;

   logic           v3_q, v3_d;
   logic [RW-1:0]  t3_q, t3_d;
   logic [RW-1:0]  xl3_q, xl3_d;

   logic           v4_q, v4_d;
   logic [DW-1:0]  r4_q, r4_d;

   logic [RW-1:0]  r_raw;
   logic [DW-1:0]  r_c1;
   logic [DW-1:0]  r_c2;

   // Bits of the quotient estimate that never reach t: the low M+1 bits are
   // shifted away and only q3 mod 2^(M+2) affects the wrapped product.
   logic           unused_q2;
   assign unused_q2 = ^{q2_q[M:0], q2_q[Q2W-1:M+1+RW]};

   assign adv           = !v4_q | bus.out_ready;
   assign bus.in_ready  = adv | rst;
   assign bus.out_valid = v4_q;
   assign bus.out_r     = r4_q;

   // x - q*P is below 3P < 2^(M+2), so the wrapped difference is exact.
   assign r_raw = xl3_q - t3_q;

   mod_csub #(.DW(DW), .P(P)) u_csub_1 (
      .a_i (DW'(r_raw)),
      .y_o (r_c1)
   );

   mod_csub #(.DW(DW), .P(P)) u_csub_2 (
      .a_i (r_c1),
      .y_o (r_c2)
   );

   // Next values for every stage: capture, quotient estimate, q*P mod 2^(M+2), residue.
   always_comb begin
      v1_d  = bus.in_valid;
      x1_d  = {bus.in_H, bus.in_L};

      v2_d  = v1_q;
      q2_d  = Q2W'(x1_q[XW-1:M-1]) * MU_Q;
      xl2_d = x1_q[RW-1:0];

      // Low bits of a product depend only on the low bits of its operands.
      v3_d  = v2_q;
      t3_d  = q2_q[M+RW:M+1] * P_R;
      xl3_d = xl2_q;

      v4_d  = v3_q;
      r4_d  = r_c2;
   end

   // Stage registers load together on advance and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         x1_q  <= '0;
         v2_q  <= 1'b0;
         q2_q  <= '0;
         xl2_q <= '0;
         v3_q  <= 1'b0;
         t3_q  <= '0;
         xl3_q <= '0;
         v4_q  <= 1'b0;
         r4_q  <= '0;
      end else if (adv) begin
         v1_q  <= v1_d;
         x1_q  <= x1_d;
         v2_q  <= v2_d;
         q2_q  <= q2_d;
         xl2_q <= xl2_d;
         v3_q  <= v3_d;
         t3_q  <= t3_d;
         xl3_q <= xl3_d;
         v4_q  <= v4_d;
         r4_q  <= r4_d;
      end
   end

endmodule

// File: tb/tb_barrett_reduce.sv
// Bench for barrett_reduce: golden residues from plain 64-bit modulo,
// scoreboard queue checked on every output transfer, plus directed
// corner, streaming, backpressure, bubble and reset scenarios.
module tb_barrett_reduce;

   localparam longint unsigned P = 64'd343576577;

   logic clk;
   logic rst;

   barrett_reduce_if #(.DW(32)) bus ();

   barrett_reduce dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int              n_total = 0;
   int              n_bad   = 0;
   int              n_out   = 0;
   longint unsigned exp_q[$];
   logic            prev_stall = 1'b0;
   logic [31:0]     prev_r     = '0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard: expected residues queued on input transfers, popped on output transfers.
   always @(negedge clk) begin
      if (rst) begin
         chk("in_ready_in_reset", bus.in_ready, 1);
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_rule", bus.in_ready, (!bus.out_valid | bus.out_ready));
         if (prev_stall) begin
            chk("stall_valid_held", bus.out_valid, 1);
            chk("stall_r_held", bus.out_r, prev_r);
         end
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_out: got r=%0d, expected no result", bus.out_r);
            end else begin
               chk("result", bus.out_r, exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back({bus.in_H, bus.in_L} % P);
         prev_stall = bus.out_valid & !bus.out_ready;
         prev_r     = bus.out_r;
      end
   end

   // One product into an empty pipe; checks latency and the literal residue.
   task automatic single(input longint unsigned x, input longint unsigned exp, input string nm);
      int k;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      {bus.in_H, bus.in_L} = x;
      @(negedge clk);
      chk({nm, "_accept"}, bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 1;
      while (!bus.out_valid && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, "_latency"}, k, 4);
      chk({nm, "_value"}, bus.out_r, exp);
      @(posedge clk); #1;
   endtask

   logic pat [24];
   logic ov  [24];

   initial begin
      longint unsigned a, b, x;
      int n0, g;
      logic [31:0] r0;

      clk = 1'b0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_L      = '0;
      bus.in_H      = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_r", bus.out_r, 0);
      chk("reset_in_ready", bus.in_ready, 1);

      // Corner values.
      single(64'd0, 64'd0, "x_zero");
      single(P, 64'd0, "x_P");
      single(2 * P - 1, 64'd343576576, "x_2P_minus_1");
      single((P - 1) * (P - 1), 64'd1, "x_max");
      single(3 * P + 7, 64'd7, "x_3P_plus_7");

      // Streaming, one product per cycle.
      n0 = n_out;
      for (int i = 0; i < 1000; i++) begin
         a = longint'($urandom) % P;
         b = longint'($urandom) % P;
         bus.in_valid = 1'b1;
         {bus.in_H, bus.in_L} = a * b;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stream_count_at_3", n_out - n0, 999);
      @(posedge clk); #1;
      chk("stream_count_at_4", n_out - n0, 1000);
      chk("stream_drained_valid", bus.out_valid, 0);
      chk("stream_queue_empty", exp_q.size(), 0);

      // Backpressure: six products, three stall cycles once output appears.
      n0 = n_out;
      fork
         begin
            logic acc;
            for (int i = 0; i < 6; i++) begin
               bus.in_valid = 1'b1;
               {bus.in_H, bus.in_L} = (P - 1 - 64'(i)) * (64'd1000 + 64'(i) * 64'd7777);
               g = 0;
               do begin
                  @(negedge clk);
                  acc = bus.in_ready;
                  @(posedge clk); #1;
                  g++;
               end while (!acc && g < 20);
               chk("bp_push_accepted", acc, 1);
            end
            bus.in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            do begin
               @(negedge clk);
               w++;
            end while (!bus.out_valid && w < 20);
            chk("bp_first_valid", bus.out_valid, 1);
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            r0 = bus.out_r;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("bp_stall_valid", bus.out_valid, 1);
               chk("bp_stall_r", bus.out_r, r0);
               chk("bp_stall_in_ready", bus.in_ready, 0);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      g = 0;
      while (exp_q.size() != 0 && g < 30) begin
         @(posedge clk); #1;
         g++;
      end
      chk("bp_drained", exp_q.size(), 0);
      chk("bp_count", n_out - n0, 6);
      @(posedge clk); #1;

      // Bubbles: alternating valid pattern must reappear four cycles later.
      for (int i = 0; i < 24; i++) begin
         pat[i] = (i < 20) && (i % 2 == 0);
         bus.in_valid = pat[i];
         {bus.in_H, bus.in_L} = 64'(i) * 64'd12345 + 64'd7 + 64'(i) * P;
         @(negedge clk);
         ov[i] = bus.out_valid;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 24; i++)
         chk("bubble_out_valid", ov[i], (i >= 4) ? pat[i - 4] : 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Reset with three products in flight.
      n0 = n_out;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         {bus.in_H, bus.in_L} = (P - 1) * 64'(i + 2);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_r", bus.out_r, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_results", n_out - n0, 0);
      single(P + 5, 64'd5, "post_reset");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
